// File: rtl/alu_share_if.sv
// alu_share_if: requester, shared-ALU and response signals of alu_share_sched
interface alu_share_if #(
  parameter int WIDTH = 32,
  parameter int CTRL_W = 4
);
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [CTRL_W-1:0] req0_op, req1_op;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
  logic [CTRL_W-1:0] alu_control;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready, rsp_zero, rsp_id, rsp_err;
  logic [WIDTH-1:0]  rsp_data;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    input  alu_out, alu_zero, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_control,
    output rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_op, req1_valid, req1_a, req1_b, req1_op,
    output alu_out, alu_zero, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_control,
    input  rsp_valid, rsp_data, rsp_zero, rsp_id, rsp_err
  );
endinterface

// File: rtl/alu_share_sched.sv
// alu_share_sched: round-robin sharing of one ALU by two requesters; ALU_SHARE_OPCHK_EN enables illegal-opcode flagging
module alu_share_sched #(
  parameter int WIDTH = 32,
  parameter int CTRL_W = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t            r_state, w_next;
  logic              r_last, r_id, r_ill, r_rsp_valid, r_rsp_zero, r_rsp_id, r_rsp_err;
  logic [WIDTH-1:0]  r_alu_a, r_alu_b, r_rsp_data;
  logic [CTRL_W-1:0] r_alu_ctrl, w_op, w_ctrl;
  logic              w_gnt, w_acc, w_ill;
`ifdef ALU_SHARE_OPCHK_EN
  assign w_ill = w_op > CTRL_W'(8);
`else
  assign w_ill = 1'b0;
`endif
  assign bus.req0_ready  = w_acc && !w_gnt;
  assign bus.req1_ready  = w_acc && w_gnt;
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_control = r_alu_ctrl;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_zero    = r_rsp_zero;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_err     = r_rsp_err;
  // round-robin grant (ties go to the side that did not win last) and next state
  always_comb begin
    w_gnt  = (bus.req0_valid && bus.req1_valid) ? !r_last : bus.req1_valid;
    w_acc  = rst_n && r_state == IDLE && (bus.req0_valid || bus.req1_valid);
    w_op   = w_gnt ? bus.req1_op : bus.req0_op;
    w_ctrl = w_ill ? '0 : w_op;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? EXEC : IDLE;
      EXEC:    w_next = RESP;
      RESP:    w_next = bus.rsp_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // state, operand capture on accept, result capture after the single EXEC cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_ill       <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_alu_a    <= w_gnt ? bus.req1_a : bus.req0_a;
        r_alu_b    <= w_gnt ? bus.req1_b : bus.req0_b;
        r_alu_ctrl <= w_ctrl;
        r_id       <= w_gnt;
        r_last     <= w_gnt;
        r_ill      <= w_ill;
      end
      if (r_state == EXEC) begin
        r_rsp_data  <= bus.alu_out;
        r_rsp_zero  <= bus.alu_zero;
        r_rsp_id    <= r_id;
        r_rsp_err   <= r_ill;
        r_rsp_valid <= 1'b1;
      end else if (r_state == RESP && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_sched.sv
// tb_alu_share_sched: directed vectors against alu_share_sched with a behavioural ALU
module tb_alu_share_sched;
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miss = 0;
  alu_share_if #(.WIDTH(32), .CTRL_W(4)) bus ();
  alu_share_sched #(.WIDTH(32), .CTRL_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef ALU_SHARE_OPCHK_EN
  localparam logic [3:0] ILL_CTRL = 4'h0;
  localparam logic       ILL_ERR  = 1'b1;
`else
  localparam logic [3:0] ILL_CTRL = 4'hA;
  localparam logic       ILL_ERR  = 1'b0;
`endif
  always #5 clk = ~clk;
  // reference ALU: default opcode behaves as add
  always_comb begin
    case (bus.alu_control)
      4'h1:    bus.alu_out = bus.alu_a - bus.alu_b;
      4'h2:    bus.alu_out = bus.alu_a & bus.alu_b;
      4'h3:    bus.alu_out = bus.alu_a | bus.alu_b;
      4'h4:    bus.alu_out = bus.alu_a ^ bus.alu_b;
      4'h6:    bus.alu_out = bus.alu_a << bus.alu_b;
      4'h7:    bus.alu_out = bus.alu_a >> bus.alu_b;
      4'h8:    bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_out = bus.alu_a + bus.alu_b;
    endcase
    bus.alu_zero = bus.alu_out == 32'd0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive0(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = v;
    bus.req0_op = op;
    bus.req0_a = a;
    bus.req0_b = b;
  endtask
  task automatic drive1(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = v;
    bus.req1_op = op;
    bus.req1_a = a;
    bus.req1_b = b;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    drive0(1'b1, 4'h0, 32'd5, 32'd7);
    drive1(1'b0, 4'h0, 32'd0, 32'd0);
    repeat (2) step();
    chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(bus.alu_control), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("single_ready0", 32'(bus.req0_ready), 32'd1);
    chk("single_ready1", 32'(bus.req1_ready), 32'd0);
    step();
    bus.req0_valid = 1'b0;
    chk("single_alu_a", bus.alu_a, 32'd5);
    chk("single_alu_b", bus.alu_b, 32'd7);
    chk("single_exec_ready0", 32'(bus.req0_ready), 32'd0);
    chk("single_exec_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_data", bus.rsp_data, 32'd12);
    chk("single_zero", 32'(bus.rsp_zero), 32'd0);
    chk("single_id", 32'(bus.rsp_id), 32'd0);
    step();
    chk("single_done", 32'(bus.rsp_valid), 32'd0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    drive0(1'b1, 4'h1, 32'd9, 32'd9);
    drive1(1'b1, 4'h4, 32'hF0, 32'h0F);
    #1;
    chk("cont_ready0", 32'(bus.req0_ready), 32'd1);
    chk("cont_ready1", 32'(bus.req1_ready), 32'd0);
    repeat (2) step();
    chk("cont0_valid", 32'(bus.rsp_valid), 32'd1);
    chk("cont0_data", bus.rsp_data, 32'd0);
    chk("cont0_zero", 32'(bus.rsp_zero), 32'd1);
    chk("cont0_id", 32'(bus.rsp_id), 32'd0);
    chk("cont_resp_ready0", 32'(bus.req0_ready), 32'd0);
    chk("cont_resp_ready1", 32'(bus.req1_ready), 32'd0);
    step();
    chk("cont_alt_ready0", 32'(bus.req0_ready), 32'd0);
    chk("cont_alt_ready1", 32'(bus.req1_ready), 32'd1);
    repeat (2) step();
    chk("cont1_data", bus.rsp_data, 32'hFF);
    chk("cont1_zero", 32'(bus.rsp_zero), 32'd0);
    chk("cont1_id", 32'(bus.rsp_id), 32'd1);
    step();
    chk("cont_back_ready0", 32'(bus.req0_ready), 32'd1);
    chk("cont_back_ready1", 32'(bus.req1_ready), 32'd0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    chk("idle_hold_valid", 32'(bus.rsp_valid), 32'd0);
    drive1(1'b1, 4'h6, 32'd1, 32'd4);
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp_ready1", 32'(bus.req1_ready), 32'd1);
    step();
    bus.req1_valid = 1'b0;
    drive0(1'b1, 4'h2, 32'hFF, 32'h0F);
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data", bus.rsp_data, 32'd16);
      chk("bp_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_ready0", 32'(bus.req0_ready), 32'd0);
      chk("bp_ready1", 32'(bus.req1_ready), 32'd0);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    chk("bp_release", 32'(bus.rsp_valid), 32'd0);
    drive0(1'b1, 4'h3, 32'd3, 32'd4);
    #1;
    chk("mid_ready0", 32'(bus.req0_ready), 32'd1);
    step();
    bus.req0_valid = 1'b0;
    chk("mid_alu_a", bus.alu_a, 32'd3);
    rst_n = 1'b0;
    step();
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_alu_a_rst", bus.alu_a, 32'd0);
    chk("mid_alu_b_rst", bus.alu_b, 32'd0);
    chk("mid_alu_ctrl_rst", 32'(bus.alu_control), 32'd0);
    chk("mid_rsp_data_rst", bus.rsp_data, 32'd0);
    chk("mid_rsp_id_rst", 32'(bus.rsp_id), 32'd0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
    drive0(1'b1, 4'h8, 32'd2, 32'd3);
    step();
    bus.req0_valid = 1'b0;
    chk("op8_ctrl", 32'(bus.alu_control), 32'd8);
    step();
    chk("op8_data", bus.rsp_data, 32'd1);
    chk("op8_err", 32'(bus.rsp_err), 32'd0);
    step();
    drive0(1'b1, 4'hA, 32'd2, 32'd3);
    step();
    bus.req0_valid = 1'b0;
    chk("ill_ctrl", 32'(bus.alu_control), 32'(ILL_CTRL));
    step();
    chk("ill_valid", 32'(bus.rsp_valid), 32'd1);
    chk("ill_data", bus.rsp_data, 32'd5);
    chk("ill_err", 32'(bus.rsp_err), 32'(ILL_ERR));
    step();
    chk("ill_done", 32'(bus.rsp_valid), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
